// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between two valid/ready requesters.
// Optional statistics counters are enabled with the macro SRAM_ARB_STATS_EN.
module sram_access_arbiter #(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]       grant0_count,
  output logic [15:0]       grant1_count,
  output logic [15:0]       conflict_count
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [2:0] WAIT_INIT = 3'(READ_LATENCY - 1);

  state_t            state, state_next;
  logic              last_grant;
  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [2:0]        wait_cnt;
  logic              gnt_port;
  logic              accept;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = we_q ? IDLE : WAIT;
      WAIT:    if (wait_cnt == 3'd0) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic; contention goes to the port that did not win last time
  always_comb begin
    gnt_port         = req1_valid && (!req0_valid || !last_grant);
    req0_ready       = 1'b0;
    req1_ready       = 1'b0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    rsp0_valid       = 1'b0;
    rsp1_valid       = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          req0_ready = req0_valid && !gnt_port;
          req1_ready = req1_valid && gnt_port;
        end
      end
      ISSUE: begin
        mem_write_enable = we_q;
        mem_read_enable  = !we_q;
      end
      RESP: begin
        rsp0_valid = !port_q;
        rsp1_valid = port_q;
      end
      default: ;
    endcase
    accept      = req0_ready || req1_ready;
    busy        = (state != IDLE);
    mem_address = addr_q;
    mem_data_in = wdata_q;
    rsp0_rdata  = rdata0_q;
    rsp1_rdata  = rdata1_q;
  end

  // Request latch, latency counter and per-port read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      wait_cnt   <= '0;
    end else begin
      if (accept) begin
        port_q     <= req1_ready;
        last_grant <= req1_ready;
        we_q       <= req1_ready ? req1_we    : req0_we;
        addr_q     <= req1_ready ? req1_addr  : req0_addr;
        wdata_q    <= req1_ready ? req1_wdata : req0_wdata;
      end
      if (state == ISSUE)
        wait_cnt <= WAIT_INIT;
      else if (state == WAIT && wait_cnt != 3'd0)
        wait_cnt <= wait_cnt - 3'd1;
      // Capture straight into the owning port's register so the other port's data is untouched
      if (state == WAIT && wait_cnt == 3'd0) begin
        if (port_q) rdata1_q <= mem_data_out;
        else        rdata0_q <= mem_data_out;
      end
    end
  end

`ifdef SRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant0_count   <= '0;
      grant1_count   <= '0;
      conflict_count <= '0;
    end else begin
      if (req0_ready && grant0_count != '1) grant0_count <= grant0_count + 16'd1;
      if (req1_ready && grant1_count != '1) grant1_count <= grant1_count + 16'd1;
      if (state == IDLE && req0_valid && req1_valid && conflict_count != '1)
        conflict_count <= conflict_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter: one instance at READ_LATENCY=1, one at 3.
// Statistics checks are compiled in when SRAM_ARB_STATS_EN is defined.
module tb_sram_access_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       preload;
  int         n_cmp = 0;
  int         n_bad = 0;

  always #5 clk = ~clk;

  // Instance with READ_LATENCY = 1
  logic       req0_valid, req0_ready, req0_we, rsp0_valid;
  logic [9:0] req0_addr;
  logic [7:0] req0_wdata, rsp0_rdata;
  logic       req1_valid, req1_ready, req1_we, rsp1_valid;
  logic [9:0] req1_addr;
  logic [7:0] req1_wdata, rsp1_rdata;
  logic       mem_write_enable, mem_read_enable, busy;
  logic [9:0] mem_address;
  logic [7:0] mem_data_in, mem_data_out;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] grant0_count, grant1_count, conflict_count;
`endif

  sram_access_arbiter #(.ADDR_W(10), .DATA_W(8), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
`ifdef SRAM_ARB_STATS_EN
    , .grant0_count(grant0_count), .grant1_count(grant1_count),
    .conflict_count(conflict_count)
`endif
  );

  // Instance with READ_LATENCY = 3
  logic       req0_valid_3, req0_ready_3, req0_we_3, rsp0_valid_3;
  logic [9:0] req0_addr_3;
  logic [7:0] req0_wdata_3, rsp0_rdata_3;
  logic       req1_valid_3, req1_ready_3, req1_we_3, rsp1_valid_3;
  logic [9:0] req1_addr_3;
  logic [7:0] req1_wdata_3, rsp1_rdata_3;
  logic       mem_write_enable_3, mem_read_enable_3, busy_3;
  logic [9:0] mem_address_3;
  logic [7:0] mem_data_in_3, mem_data_out_3;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] grant0_count_3, grant1_count_3, conflict_count_3;
`endif

  sram_access_arbiter #(.ADDR_W(10), .DATA_W(8), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid_3), .req0_ready(req0_ready_3), .req0_we(req0_we_3),
    .req0_addr(req0_addr_3), .req0_wdata(req0_wdata_3),
    .rsp0_valid(rsp0_valid_3), .rsp0_rdata(rsp0_rdata_3),
    .req1_valid(req1_valid_3), .req1_ready(req1_ready_3), .req1_we(req1_we_3),
    .req1_addr(req1_addr_3), .req1_wdata(req1_wdata_3),
    .rsp1_valid(rsp1_valid_3), .rsp1_rdata(rsp1_rdata_3),
    .mem_write_enable(mem_write_enable_3), .mem_read_enable(mem_read_enable_3),
    .mem_address(mem_address_3), .mem_data_in(mem_data_in_3),
    .mem_data_out(mem_data_out_3), .busy(busy_3)
`ifdef SRAM_ARB_STATS_EN
    , .grant0_count(grant0_count_3), .grant1_count(grant1_count_3),
    .conflict_count(conflict_count_3)
`endif
  );

  // SRAM models: 1-cycle synchronous read, and a 3-stage read pipeline
  logic [7:0] mem1 [0:1023];
  logic [7:0] rd1;
  always @(posedge clk) begin
    if (mem_write_enable) mem1[mem_address] <= mem_data_in;
    if (mem_read_enable)  rd1 <= mem1[mem_address];
  end
  assign mem_data_out = rd1;

  logic [7:0] mem3 [0:1023];
  logic [7:0] p1, p2, p3;
  always @(posedge clk) begin
    if (preload)               mem3[10'h155] <= 8'h5C;
    else if (mem_write_enable_3) mem3[mem_address_3] <= mem_data_in_3;
    p1 <= mem_read_enable_3 ? mem3[mem_address_3] : 8'h00;
    p2 <= p1;
    p3 <= p2;
  end
  assign mem_data_out_3 = p3;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_we = 0; req1_addr = '0; req1_wdata = '0;
    req0_valid_3 = 0; req0_we_3 = 0; req0_addr_3 = '0; req0_wdata_3 = '0;
    req1_valid_3 = 0; req1_we_3 = 0; req1_addr_3 = '0; req1_wdata_3 = '0;

    // Reset state, with a request already presented during reset
    @(negedge clk); preload = 1'b0;
    req0_valid = 1; req0_we = 1; req0_addr = 10'h080; req0_wdata = 8'hAA;
    #1;
    check("rst_ready0", 16'(req0_ready), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_mem_we", 16'(mem_write_enable), 16'h0);
    check("rst_mem_addr", 16'(mem_address), 16'h0);
    check("rst_rdata0", 16'(rsp0_rdata), 16'h0);
    @(negedge clk); rst_n = 1'b1;
    #1 check("wr_ready0", 16'(req0_ready), 16'h1);

    // Single write from port 0
    @(negedge clk);
    check("wr_issue_we", 16'(mem_write_enable), 16'h1);
    check("wr_issue_re", 16'(mem_read_enable), 16'h0);
    check("wr_issue_addr", 16'(mem_address), 16'h080);
    check("wr_issue_data", 16'(mem_data_in), 16'h0AA);
    check("wr_issue_busy", 16'(busy), 16'h1);
    check("wr_issue_ready0", 16'(req0_ready), 16'h0);
    req0_valid = 0;
    @(negedge clk);
    check("wr_done_we", 16'(mem_write_enable), 16'h0);
    check("wr_done_busy", 16'(busy), 16'h0);
    check("wr_hold_addr", 16'(mem_address), 16'h080);
    check("wr_no_rsp0", 16'(rsp0_valid), 16'h0);

    // Read-back from port 1
    req1_valid = 1; req1_we = 0; req1_addr = 10'h080;
    #1 check("rd_ready1", 16'(req1_ready), 16'h1);
    @(negedge clk);
    check("rd_issue_re", 16'(mem_read_enable), 16'h1);
    check("rd_issue_we", 16'(mem_write_enable), 16'h0);
    req1_valid = 0;
    @(negedge clk);
    check("rd_wait_rsp1", 16'(rsp1_valid), 16'h0);
    check("rd_wait_busy", 16'(busy), 16'h1);
    @(negedge clk);
    check("rd_rsp1_valid", 16'(rsp1_valid), 16'h1);
    check("rd_rsp1_rdata", 16'(rsp1_rdata), 16'h0AA);
    check("rd_rsp0_quiet", 16'(rsp0_valid), 16'h0);
    @(negedge clk);
    check("rd_after_rsp1", 16'(rsp1_valid), 16'h0);
    check("rd_hold_rdata1", 16'(rsp1_rdata), 16'h0AA);
    check("rd_after_busy", 16'(busy), 16'h0);

    // Contention from reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    req0_valid = 1; req0_we = 1; req0_addr = 10'h001; req0_wdata = 8'h11;
    req1_valid = 1; req1_we = 1; req1_addr = 10'h002; req1_wdata = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("ct_ready0", 16'(req0_ready), (i % 2 == 0) ? 16'h1 : 16'h0);
      check("ct_ready1", 16'(req1_ready), (i % 2 == 0) ? 16'h0 : 16'h1);
      @(negedge clk);
      check("ct_issue_we", 16'(mem_write_enable), 16'h1);
      check("ct_issue_addr", 16'(mem_address), (i % 2 == 0) ? 16'h001 : 16'h002);
      check("ct_issue_data", 16'(mem_data_in), (i % 2 == 0) ? 16'h011 : 16'h022);
      check("ct_issue_ready0", 16'(req0_ready), 16'h0);
      if (i == 3) begin req0_valid = 0; req1_valid = 0; end
      @(negedge clk);
    end
    check("ct_idle_busy", 16'(busy), 16'h0);

    // Reset during WAIT of a port-1 read
    req1_valid = 1; req1_we = 0; req1_addr = 10'h002;
    #1 check("mr_ready1", 16'(req1_ready), 16'h1);
    @(negedge clk);
    check("mr_issue_re", 16'(mem_read_enable), 16'h1);
    req1_valid = 0;
    @(negedge clk);
    check("mr_wait_busy", 16'(busy), 16'h1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_no_rsp1", 16'(rsp1_valid), 16'h0);
    check("mr_busy", 16'(busy), 16'h0);
    check("mr_re", 16'(mem_read_enable), 16'h0);
    check("mr_addr", 16'(mem_address), 16'h0);
    check("mr_data_in", 16'(mem_data_in), 16'h0);
    check("mr_rdata1", 16'(rsp1_rdata), 16'h0);
    rst_n = 1'b1;
    req0_valid = 1; req0_we = 0; req0_addr = 10'h001;
    req1_valid = 1; req1_we = 0; req1_addr = 10'h002;
    #1;
    check("mr_post_ready0", 16'(req0_ready), 16'h1);
    check("mr_post_ready1", 16'(req1_ready), 16'h0);
    @(negedge clk);
    check("mr_post_addr", 16'(mem_address), 16'h001);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("mr_post_rsp0", 16'(rsp0_valid), 16'h1);
    check("mr_post_rdata0", 16'(rsp0_rdata), 16'h011);
    check("mr_post_rsp1", 16'(rsp1_valid), 16'h0);
    @(negedge clk);

    // READ_LATENCY = 3 instance
    req0_valid_3 = 1; req0_we_3 = 0; req0_addr_3 = 10'h155;
    #1 check("l3_ready0", 16'(req0_ready_3), 16'h1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req0_valid_3 = 0;
      check("l3_busy", 16'(busy_3), (k <= 5) ? 16'h1 : 16'h0);
      check("l3_rsp0", 16'(rsp0_valid_3), (k == 5) ? 16'h1 : 16'h0);
      if (k == 5) begin
        check("l3_rdata0", 16'(rsp0_rdata_3), 16'h05C);
        check("l3_rsp1", 16'(rsp1_valid_3), 16'h0);
        check("l3_we", 16'(mem_write_enable_3), 16'h0);
      end
    end
    check("l3_ready1", 16'(req1_ready_3), 16'h0);
    check("l3_rdata1", 16'(rsp1_rdata_3), 16'h0);

`ifdef SRAM_ARB_STATS_EN
    rst_n = 1'b0;
    @(negedge clk);
    check("st_rst_g0", grant0_count, 16'h0);
    check("st_rst_cf", conflict_count, 16'h0);
    rst_n = 1'b1;
    req0_valid = 1; req0_we = 1; req0_addr = 10'h001; req0_wdata = 8'h11;
    req1_valid = 1; req1_we = 1; req1_addr = 10'h002; req1_wdata = 8'h22;
    for (int i = 0; i < 6; i++) begin
      #1 check("st_ready0", 16'(req0_ready), (i % 2 == 0) ? 16'h1 : 16'h0);
      @(negedge clk);
      if (i == 5) begin req0_valid = 0; req1_valid = 0; end
      @(negedge clk);
    end
    check("st_grant0", grant0_count, 16'd3);
    check("st_grant1", grant1_count, 16'd3);
    check("st_conflict", conflict_count, 16'd6);
    check("st_l3_grant1", grant1_count_3, 16'd0);
    check("st_l3_grant0", grant0_count_3, 16'd0);
    check("st_l3_conflict", conflict_count_3, 16'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares one `sram_memory_controller` instance (8-bit data, 10-bit address, `write_enable`/`read_enable`/`data_out`) between two requesters.
- Requesters use valid/ready requests; the arbiter grants round-robin and drives one SRAM access at a time.
- Read data returns to the originating requester with a one-cycle response pulse.
- Sits between client logic (e.g. DMA, CPU-side) and the SRAM controller.

Parameters:
- ADDR_W, 10, address width.
- DATA_W, 8, data width.
- READ_LATENCY, 1, cycles from the mem_read_enable cycle until mem_data_out is valid (legal range 1..7).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle when valid&ready.
- req0_we  in  1  port 0: 1=write, 0=read.
- req0_addr  in  ADDR_W  port 0 address.
- req0_wdata  in  DATA_W  port 0 write data.
- rsp0_valid  out  1  port 0 read-data pulse.
- rsp0_rdata  out  DATA_W  port 0 read data.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata, rsp1_valid, rsp1_rdata: same as port 0, for port 1.
- mem_write_enable  out  1  to SRAM write_enable.
- mem_read_enable  out  1  to SRAM read_enable.
- mem_address  out  ADDR_W  to SRAM address.
- mem_data_in  out  DATA_W  to SRAM data_in.
- mem_data_out  in  DATA_W  from SRAM data_out.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst_n=0 at rising edge):
  - state=IDLE; last_grant=1, so port 0 wins the first contention.
  - All outputs 0.
  - Any in-flight access is abandoned; no rsp pulse is issued for it.
- States:
  - IDLE: accepts a request.
  - ISSUE: drives the SRAM access.
  - WAIT: waits out READ_LATENCY.
  - RESP: presents read data.
- Grant (IDLE only, combinational):
  - Only req0_valid → port 0; only req1_valid → port 1.
  - Both valid → the port != last_grant.
  - reqN_ready=1 only for the granted port while in IDLE; 0 in every other state and during reset.
- Handshake: reqN_valid & reqN_ready at an edge latches we/addr/wdata and the port id, updates last_grant, and moves to ISSUE.
  - reqN_valid may drop without a handshake; no state change results.
- ISSUE (exactly 1 cycle):
  - mem_address = latched addr; mem_data_in = latched wdata.
  - Write: mem_write_enable=1, then → IDLE.
  - Read: mem_read_enable=1, then → WAIT.
  - Both enables are never high together; both are 0 outside ISSUE.
  - mem_address and mem_data_in hold their last values outside ISSUE.
- WAIT:
  - A 3-bit counter loads READ_LATENCY-1 on ISSUE exit and decrements.
  - At count 0, capture mem_data_out into the rdata register, then → RESP.
  - With READ_LATENCY=1, WAIT lasts 1 cycle.
- RESP (exactly 1 cycle):
  - rspN_valid=1 for the latched port only; rspN_rdata = captured data.
  - Then → IDLE.
  - rspN_rdata holds its value after the pulse; the other port's rdata is unchanged.
- Timing (handshake at edge T):
  - Write: ISSUE during T+1; the next accept can occur at edge T+2.
  - Read, READ_LATENCY=L: ISSUE during T+1, WAIT during T+2..T+1+L, rsp_valid during T+2+L, IDLE at T+3+L.
- Back-to-back: a requester holding valid continuously is accepted again on its next IDLE cycle.
  - If the other port is also valid, round-robin alternates grants strictly.
- Requests carry no ordering between ports; each port's responses return in its own request order, since only one access is outstanding.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- Defined:
  - Adds outputs grant0_count and grant1_count (16-bit each, reset 0).
  - Each increments on its port's handshake and saturates at 16'hFFFF.
  - Adds output conflict_count (16-bit, saturating): increments on every IDLE cycle where both req valids are high.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset then single write: port 0 writes addr 10'h080, data 8'hAA → req0_ready=1 in cycle 0; mem_write_enable=1 for exactly one cycle with mem_address=10'h080 and mem_data_in=8'hAA; no rsp0_valid.
- Read-back, READ_LATENCY=1: port 1 reads 10'h080 → rsp1_valid for one cycle, 3 cycles after the handshake, rsp1_rdata=8'hAA; rsp0_valid stays 0.
- Contention: both ports valid from reset, port 0 writing 8'h11 to 10'h001 and port 1 writing 8'h22 to 10'h002, held 4 grants → grant order 0,1,0,1; mem_write_enable high on alternate-accept ISSUE cycles.
- Mid-access reset: assert rst_n=0 in the WAIT cycle of a read → no rsp pulse; all outputs 0 next cycle; busy=0; after release, port 0 is granted first under contention.
- READ_LATENCY=3: read of a preloaded 8'h5C → rsp_valid exactly 5 cycles after the handshake; busy high for 5 cycles.
- With SRAM_ARB_STATS_EN defined: run the contention test for 6 grants → grant0_count=3, grant1_count=3, conflict_count=6.
